// File: rtl/conv_interleaver_commutator_pkg.sv
// Shared constants and sync-FSM encoding for the 12-branch convolutional byte
// interleaver commutator (also used by the matching deinterleaver).
package conv_interleaver_commutator_pkg;

    localparam int DEF_NUM_BRANCH   = 12;
    localparam int DEF_DATA_W       = 8;
    localparam int DEF_BRANCH_DEPTH = 17;
    localparam int DEF_PKT_LEN      = 204;
    localparam int DEF_LOCK_CNT     = 3;
    localparam int DEF_LOSS_CNT     = 2;
    localparam logic [7:0] DEF_SYNC_BYTE = 8'h47;

    typedef enum logic [1:0] {
        ST_SEARCH = 2'd0,
        ST_VERIFY = 2'd1,
        ST_LOCKED = 2'd2
    } sync_state_t;

endpackage

// File: rtl/conv_interleaver_commutator_ts_sync_lock.sv
// Transport-stream sync tracker: SEARCH/VERIFY/LOCKED FSM with a packet byte
// counter and saturating sync hit/miss counters.
module conv_interleaver_commutator_ts_sync_lock
    import conv_interleaver_commutator_pkg::*;
#(
    parameter int              DATA_W    = DEF_DATA_W,
    parameter logic [DATA_W-1:0] SYNC_BYTE = DEF_SYNC_BYTE,
    parameter int              PKT_LEN   = DEF_PKT_LEN,
    parameter int              LOCK_CNT  = DEF_LOCK_CNT,
    parameter int              LOSS_CNT  = DEF_LOSS_CNT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] data_in,
    output logic              locked,
    output logic              cnt_zero,
    output logic              lock_entry
);

    localparam int CNT_W  = $clog2(PKT_LEN);
    localparam int HIT_W  = $clog2(LOCK_CNT + 1);
    localparam int MISS_W = $clog2(LOSS_CNT + 1);

    sync_state_t       state_reg;
    logic [CNT_W-1:0]  byte_cnt_reg;
    logic [HIT_W-1:0]  hit_reg;
    logic [MISS_W-1:0] miss_reg;

    logic              is_sync;
    logic [CNT_W-1:0]  byte_cnt_next;
    logic [HIT_W-1:0]  hit_next;
    logic [MISS_W-1:0] miss_next;

    assign is_sync       = (data_in == SYNC_BYTE);
    assign cnt_zero      = (byte_cnt_reg == '0);
    assign byte_cnt_next = (byte_cnt_reg == CNT_W'(PKT_LEN - 1)) ? '0 : byte_cnt_reg + 1'b1;
    assign hit_next      = (hit_reg == HIT_W'(LOCK_CNT)) ? hit_reg : hit_reg + 1'b1;
    assign miss_next     = (miss_reg == MISS_W'(LOSS_CNT)) ? miss_reg : miss_reg + 1'b1;
    assign locked        = (state_reg == ST_LOCKED);

    // Combinational so the byte that completes locking is itself interleaved.
    assign lock_entry = in_valid && (state_reg == ST_VERIFY) && cnt_zero && is_sync
                        && (hit_next == HIT_W'(LOCK_CNT));

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= ST_SEARCH;
            byte_cnt_reg <= '0;
            hit_reg      <= '0;
            miss_reg     <= '0;
        end else if (in_valid) begin
            case (state_reg)
                ST_SEARCH: begin
                    if (is_sync) begin
                        state_reg    <= ST_VERIFY;
                        byte_cnt_reg <= CNT_W'(1);
                        hit_reg      <= HIT_W'(1);
                    end
                end
                ST_VERIFY: begin
                    byte_cnt_reg <= byte_cnt_next;
                    if (cnt_zero) begin
                        if (is_sync) begin
                            hit_reg <= hit_next;
                            if (hit_next == HIT_W'(LOCK_CNT)) begin
                                state_reg <= ST_LOCKED;
                                miss_reg  <= '0;
                            end
                        end else begin
                            state_reg    <= ST_SEARCH;
                            byte_cnt_reg <= '0;
                            hit_reg      <= '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    byte_cnt_reg <= byte_cnt_next;
                    if (cnt_zero) begin
                        if (is_sync) begin
                            miss_reg <= '0;
                        end else if (miss_next == MISS_W'(LOSS_CNT)) begin
                            state_reg    <= ST_SEARCH;
                            byte_cnt_reg <= '0;
                            hit_reg      <= '0;
                            miss_reg     <= '0;
                        end else begin
                            miss_reg <= miss_next;
                        end
                    end
                end
                default: begin
                    state_reg    <= ST_SEARCH;
                    byte_cnt_reg <= '0;
                    hit_reg      <= '0;
                    miss_reg     <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/conv_interleaver_commutator.sv
// Input/output commutator of the convolutional byte interleaver: steps a
// round-robin branch pointer once locked and muxes the departing branch byte.
module conv_interleaver_commutator
    import conv_interleaver_commutator_pkg::*;
#(
    parameter int                NUM_BRANCH = DEF_NUM_BRANCH,
    parameter int                DATA_W     = DEF_DATA_W,
    parameter logic [DATA_W-1:0] SYNC_BYTE  = DEF_SYNC_BYTE,
    parameter int                PKT_LEN    = DEF_PKT_LEN,
    parameter int                LOCK_CNT   = DEF_LOCK_CNT,
    parameter int                LOSS_CNT   = DEF_LOSS_CNT
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [DATA_W-1:0]            data_in,
    output logic [NUM_BRANCH-1:0]        br_en,
    output logic [DATA_W-1:0]            br_wdata,
    input  logic [NUM_BRANCH*DATA_W-1:0] br_rdata,
    output logic [DATA_W-1:0]            data_out,
    output logic                         out_valid,
    output logic                         pkt_start,
    output logic                         locked
);

    localparam int PTR_W = $clog2(NUM_BRANCH);

    logic              sync_locked;
    logic              cnt_zero;
    logic              lock_entry;
    logic              process_byte;
    logic [PTR_W-1:0]  br_ptr_reg;
    logic [PTR_W-1:0]  cur_ptr;
    logic [PTR_W-1:0]  br_ptr_next;
    logic [DATA_W-1:0] sel_data;
    logic [DATA_W-1:0] rdata_arr [NUM_BRANCH];

    conv_interleaver_commutator_ts_sync_lock #(
        .DATA_W    (DATA_W),
        .SYNC_BYTE (SYNC_BYTE),
        .PKT_LEN   (PKT_LEN),
        .LOCK_CNT  (LOCK_CNT),
        .LOSS_CNT  (LOSS_CNT)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .data_in    (data_in),
        .locked     (sync_locked),
        .cnt_zero   (cnt_zero),
        .lock_entry (lock_entry)
    );

    assign process_byte = in_valid && (sync_locked || lock_entry);
    // On lock entry the pointer restarts at branch 0, whatever stale value it held.
    assign cur_ptr      = lock_entry ? '0 : br_ptr_reg;
    assign br_ptr_next  = (cur_ptr == PTR_W'(NUM_BRANCH - 1)) ? '0 : cur_ptr + 1'b1;
    assign br_wdata     = data_in;
    assign locked       = sync_locked;

    for (genvar gi = 0; gi < NUM_BRANCH; gi++) begin : g_branch
        assign rdata_arr[gi] = br_rdata[gi*DATA_W +: DATA_W];
        if (gi == 0) begin : g_direct
            assign br_en[gi] = 1'b0;
        end else begin : g_delayed
            assign br_en[gi] = !reset && process_byte && (cur_ptr == PTR_W'(gi));
        end
    end

    assign sel_data = (cur_ptr == '0) ? data_in : rdata_arr[cur_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            br_ptr_reg <= '0;
            data_out   <= '0;
            out_valid  <= 1'b0;
            pkt_start  <= 1'b0;
        end else if (process_byte) begin
            br_ptr_reg <= br_ptr_next;
            data_out   <= sel_data;
            out_valid  <= 1'b1;
            pkt_start  <= cnt_zero && (cur_ptr == '0);
        end else begin
            out_valid  <= 1'b0;
            pkt_start  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_interleaver_commutator.sv
// Bench for the interleaver commutator: attaches 12 branch delay lines and
// scoreboards every output byte against a per-branch write history.
module tb_conv_interleaver_commutator;

    localparam int NB    = 12;
    localparam int DW    = 8;
    localparam int DEPTH = 17;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] data_in;
    logic [NB-1:0] br_en;
    logic [DW-1:0] br_wdata;
    logic [NB*DW-1:0] br_rdata;
    logic [DW-1:0] data_out;
    logic          out_valid;
    logic          pkt_start;
    logic          locked;

    always #5 clk = ~clk;

    conv_interleaver_commutator dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .data_in   (data_in),
        .br_en     (br_en),
        .br_wdata  (br_wdata),
        .br_rdata  (br_rdata),
        .data_out  (data_out),
        .out_valid (out_valid),
        .pkt_start (pkt_start),
        .locked    (locked)
    );

    // Branch delay lines as the parent would build them: never flushed.
    logic [DW-1:0] br_mem [NB][NB*DEPTH] = '{default: '{default: 8'h00}};

    always @(posedge clk) begin
        for (int j = 1; j < NB; j++) begin
            if (br_en[j]) begin
                for (int k = j*DEPTH - 1; k > 0; k--) br_mem[j][k] <= br_mem[j][k-1];
                br_mem[j][0] <= br_wdata;
            end
        end
    end

    always_comb begin
        br_rdata = '0;
        br_rdata[DW-1:0] = 8'hA5;
        for (int j = 1; j < NB; j++) br_rdata[j*DW +: DW] = br_mem[j][j*DEPTH - 1];
    end

    typedef struct packed {
        logic [DW-1:0] d;
        logic          ps;
    } exp_t;

    exp_t          exp_q [$];
    exp_t          mon_e;
    logic [DW-1:0] hist [NB][1024];
    int            wcnt [NB];
    int            checks   = 0;
    int            failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, req, $time);
        end
    endtask

    // Monitor: every presented output must match the oldest expectation.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_out actual=%0h required=no_output time=%0t", data_out, $time);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", 32'(data_out), 32'(mon_e.d));
                check("out_pkt_start", 32'(pkt_start), 32'(mon_e.ps));
                $display("out data=%02h pkt_start=%0b", data_out, pkt_start);
            end
        end
    end

    function automatic logic [DW-1:0] pay(input int pk, input int pos);
        logic [DW-1:0] b;
        b = 8'((pk*37 + pos*11 + 3) & 255);
        if (b == 8'h47) b = 8'h48;
        return b;
    endfunction

    // Entered and left at posedge+1; proc says whether the DUT should interleave it.
    task automatic send_byte(input logic [DW-1:0] b, input bit proc, input int pos, input bit gaps);
        int            j;
        logic [DW-1:0] ev;
        logic [NB-1:0] een;
        while (gaps && ($urandom_range(0, 1) == 1)) begin
            in_valid = 1'b0;
            data_in  = 8'($urandom_range(0, 255));
            #1;
            check("gap_br_en", 32'(br_en), 32'd0);
            @(posedge clk); #1;
        end
        j        = pos % NB;
        in_valid = 1'b1;
        data_in  = b;
        een      = '0;
        if (proc) begin
            if (j == 0)                     ev = b;
            else if (wcnt[j] >= DEPTH*j)    ev = hist[j][wcnt[j] - DEPTH*j];
            else                            ev = 8'h00;
            exp_q.push_back('{d: ev, ps: (pos == 0)});
            if (j > 0) begin
                hist[j][wcnt[j]] = b;
                wcnt[j]++;
                een[j] = 1'b1;
            end
        end
        #1;
        check("br_en", 32'(br_en), 32'(een));
        check("br_wdata", 32'(br_wdata), 32'(b));
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // mode 0: nothing processed, 1: whole packet, 2: only the sync byte.
    task automatic send_pkt(input logic [DW-1:0] sync, input int pk, input int mode,
                            input bit gaps, input bit exp_lock, input int len);
        bit pr;
        for (int p = 0; p < len; p++) begin
            pr = (mode == 1) || ((mode == 2) && (p == 0));
            send_byte((p == 0) ? sync : pay(pk, p), pr, p, gaps);
            if (p == 0) begin
                check("sync_out_valid", 32'(out_valid), 32'(pr));
                check("locked", 32'(locked), 32'(exp_lock));
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"}, 32'(data_out), 32'd0);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_pkt_start"}, 32'(pkt_start), 32'd0);
        check({tag, "_locked"}, 32'(locked), 32'd0);
        check({tag, "_br_en"}, 32'(br_en), 32'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        data_in  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;

        // Initial lock on the third sync, then a long locked run.
        send_pkt(8'h47, 0, 0, 1'b0, 1'b0, 204);
        send_pkt(8'h47, 1, 0, 1'b0, 1'b0, 204);
        send_pkt(8'h47, 2, 1, 1'b0, 1'b1, 204);
        for (int pk = 3; pk < 14; pk++) send_pkt(8'h47, pk, 1, 1'b0, 1'b1, 204);

        // Random in_valid gaps.
        for (int pk = 14; pk < 18; pk++) send_pkt(8'h47, pk, 1, 1'b1, 1'b1, 204);

        // One lost sync is tolerated; two consecutive drop lock, then relock.
        send_pkt(8'h00, 18, 1, 1'b0, 1'b1, 204);
        send_pkt(8'h47, 19, 1, 1'b0, 1'b1, 204);
        send_pkt(8'h00, 20, 1, 1'b0, 1'b1, 204);
        send_pkt(8'h00, 21, 2, 1'b0, 1'b0, 204);
        send_pkt(8'h47, 22, 0, 1'b0, 1'b0, 204);
        send_pkt(8'h47, 23, 0, 1'b0, 1'b0, 204);
        send_pkt(8'h47, 24, 1, 1'b0, 1'b1, 204);
        send_pkt(8'h47, 25, 1, 1'b0, 1'b1, 204);

        // VERIFY failures: near-miss sync, then a false sync inside payload.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        send_pkt(8'h47, 26, 0, 1'b0, 1'b0, 204);
        send_pkt(8'h46, 27, 0, 1'b0, 1'b0, 204);
        for (int i = 0; i < 280; i++) send_byte((i == 30) ? 8'h47 : pay(50, i), 1'b0, i, 1'b0);
        check("false_sync_locked", 32'(locked), 32'd0);
        send_pkt(8'h47, 28, 0, 1'b0, 1'b0, 204);
        send_pkt(8'h47, 29, 0, 1'b0, 1'b0, 204);
        send_pkt(8'h47, 30, 1, 1'b0, 1'b1, 204);

        // Reset mid-packet while locked, then a fresh lock.
        send_pkt(8'h47, 31, 1, 1'b0, 1'b1, 204);
        send_pkt(8'h47, 32, 1, 1'b0, 1'b1, 100);
        reset = 1'b1;
        @(posedge clk); #1;
        check_all_zero("midreset");
        reset = 1'b0;
        for (int i = 100; i < 204; i++) send_byte(pay(99, i), 1'b0, i, 1'b0);
        send_pkt(8'h47, 33, 0, 1'b0, 1'b0, 204);
        send_pkt(8'h47, 34, 0, 1'b0, 1'b0, 204);
        send_pkt(8'h47, 35, 1, 1'b0, 1'b1, 204);
        send_pkt(8'h47, 36, 1, 1'b0, 1'b1, 204);

        repeat (3) @(posedge clk);
        #1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
